// File: rtl/ar_pkg.sv
// ============================================================================
// Module   : ar_pkg
// Brief    : Shared constants and state encoding for the product accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ar_pkg;

    localparam int PROD_W        = 64;
    localparam int GUARD_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } ar_state_t;

endpackage

`default_nettype wire

// File: rtl/ar_acc_add.sv
// ============================================================================
// Module   : ar_acc_add
// Brief    : Accumulator adder with carry-out detection; optional clamping
//            selected by macro AR_ACC_SAT_EN (undefined -> modulo wrap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ar_acc_add
    import ar_pkg::*;
#(
    parameter int GUARD = GUARD_DEFAULT
) (
    input  logic [PROD_W+GUARD-1:0] i_acc,
    input  logic [PROD_W-1:0]       i_prod,
    input  logic                    i_ovf,
    input  logic                    i_load,
    output logic [PROD_W+GUARD-1:0] o_sum,
    output logic                    o_ovf
);

    localparam int ACC_W = PROD_W + GUARD;

    logic [ACC_W:0] w_full;
    logic           w_carry;

    assign w_full  = {1'b0, i_acc} + {{(GUARD + 1){1'b0}}, i_prod};
    assign w_carry = w_full[ACC_W];

    always_comb begin
        o_sum = w_full[ACC_W-1:0];
        o_ovf = i_ovf | w_carry;
        if (i_load) begin
            // First term of a sum: no history, so overflow restarts clear.
            o_sum = {{GUARD{1'b0}}, i_prod};
            o_ovf = 1'b0;
        end else begin
`ifdef AR_ACC_SAT_EN
            // Once clamped, the sum stays pinned for the rest of the sum.
            if (i_ovf | w_carry) begin
                o_sum = '1;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/ar_acc_64.sv
// ============================================================================
// Module   : ar_acc_64
// Brief    : Valid/ready accumulator of 64-bit products into framed sums.
//            Optional macro AR_ACC_SAT_EN clamps the sum on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ar_acc_64
    import ar_pkg::*;
#(
    parameter int GUARD = GUARD_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PROD_W-1:0]       in_prod,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [PROD_W+GUARD-1:0] out_sum,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int ACC_W = PROD_W + GUARD;

    ar_state_t          r_state;
    ar_state_t          w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_out_ovf;

    logic               w_xfer_in;
    logic               w_load;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_ovf_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    // HOLD only blocks new terms while the result is still unclaimed.
    assign in_ready  = (r_state != HOLD) | out_ready;
    assign w_xfer_in = in_valid & in_ready;
    assign w_load    = (r_state != ACCUM);

    ar_acc_add #(
        .GUARD (GUARD)
    ) u_add (
        .i_acc  (r_acc),
        .i_prod (in_prod),
        .i_ovf  (r_ovf),
        .i_load (w_load),
        .o_sum  (w_acc_nxt),
        .o_ovf  (w_ovf_nxt)
    );

    always_comb begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_load) begin
            w_cnt_nxt = {{(CNT_W - 1){1'b0}}, 1'b1};
        end else if (&r_cnt) begin
            w_cnt_nxt = r_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer_in) begin
            w_state_nxt = in_last ? HOLD : ACCUM;
        end else if ((r_state == HOLD) && out_ready) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_xfer_in) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            if (in_last) begin
                r_out_sum <= w_acc_nxt;
                r_out_cnt <= w_cnt_nxt;
                r_out_ovf <= w_ovf_nxt;
            end
        end
    end

    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;
    assign out_valid = (r_state == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_ar_acc_64.sv
// ============================================================================
// Module   : tb_ar_acc_64
// Brief    : Directed self-checking bench for ar_acc_64 (default and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ar_acc_64;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_prod;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic [71:0] out_sum;
    logic [15:0] out_cnt;
    logic        out_ovf;
    logic        out_valid;

    logic        in_ready_s;
    logic [71:0] out_sum_s;
    logic [1:0]  out_cnt_s;
    logic        out_ovf_s;
    logic        out_valid_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ar_acc_64 #(.GUARD(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    ar_acc_64 #(.GUARD(8), .CNT_W(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready_s),
        .out_sum   (out_sum_s),
        .out_cnt   (out_cnt_s),
        .out_ovf   (out_ovf_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready)
    );

    task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one term for exactly one edge; caller guarantees in_ready.
    task automatic term(input logic [63:0] p, input logic l);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [71:0] sum_hold;
    logic [71:0] exp_big;

    initial begin
        rst       = 1'b1;
        in_prod   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();

        check_val("rst_valid", {71'd0, out_valid}, 72'd0);
        check_val("rst_sum",   out_sum, 72'd0);
        check_val("rst_cnt",   {56'd0, out_cnt}, 72'd0);
        check_val("rst_ovf",   {71'd0, out_ovf}, 72'd0);
        check_val("rst_ready", {71'd0, in_ready}, 72'd1);
        rst = 1'b0;
        step();
        check_val("idle_ready", {71'd0, in_ready}, 72'd1);

        // 3 + 5 + 7
        out_ready = 1'b1;
        term(64'd3, 1'b0);
        check_val("t1_mid_valid", {71'd0, out_valid}, 72'd0);
        term(64'd5, 1'b0);
        term(64'd7, 1'b1);
        check_val("t1_valid", {71'd0, out_valid}, 72'd1);
        check_val("t1_sum",   out_sum, 72'd15);
        check_val("t1_cnt",   {56'd0, out_cnt}, 72'd3);
        check_val("t1_ovf",   {71'd0, out_ovf}, 72'd0);
        step();
        check_val("t1_drain_valid", {71'd0, out_valid}, 72'd0);
        check_val("t1_drain_ready", {71'd0, in_ready}, 72'd1);

        // Held result with back-pressure; an offered term must be refused.
        out_ready = 1'b0;
        term(64'hFFFF_FFFE_0000_0001, 1'b1);
        sum_hold = {8'h00, 64'hFFFF_FFFE_0000_0001};
        in_valid = 1'b1;
        in_prod  = 64'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("t2_valid", {71'd0, out_valid}, 72'd1);
            check_val("t2_ready", {71'd0, in_ready}, 72'd0);
            check_val("t2_sum",   out_sum, sum_hold);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_val("t2_cnt_after", {56'd0, out_cnt}, 72'd1);
        check_val("t2_sum_after", out_sum, sum_hold);
        out_ready = 1'b1;
        step();
        check_val("t2_release_valid", {71'd0, out_valid}, 72'd0);
        check_val("t2_release_ready", {71'd0, in_ready}, 72'd1);

        // New single-term sum accepted in the same cycle the old one drains.
        term(64'd5, 1'b1);
        check_val("t4_first_sum",   out_sum, 72'd5);
        check_val("t4_first_valid", {71'd0, out_valid}, 72'd1);
        term(64'd9, 1'b1);
        check_val("t4_valid", {71'd0, out_valid}, 72'd1);
        check_val("t4_sum",   out_sum, 72'd9);
        check_val("t4_cnt",   {56'd0, out_cnt}, 72'd1);
        step();

        // Asynchronous reset in the middle of a partial sum.
        term(64'd10, 1'b0);
        term(64'd20, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_rst_sum",   out_sum, 72'd0);
        check_val("t5_rst_cnt",   {56'd0, out_cnt}, 72'd0);
        check_val("t5_rst_valid", {71'd0, out_valid}, 72'd0);
        check_val("t5_rst_ready", {71'd0, in_ready}, 72'd1);
        @(negedge clk);
        rst = 1'b0;
        term(64'd4, 1'b1);
        check_val("t5_sum", out_sum, 72'd4);
        check_val("t5_cnt", {56'd0, out_cnt}, 72'd1);
        step();

        // 257 * (2^64-1) = 2^72 + 2^64 - 257, so the wrapped sum is 2^64 - 257.
`ifdef AR_ACC_SAT_EN
        exp_big = {72{1'b1}};
`else
        exp_big = 72'h00_FFFF_FFFF_FFFF_FEFF;
`endif
        for (int i = 0; i < 256; i++) begin
            term({64{1'b1}}, 1'b0);
        end
        check_val("t3_pre_ovf_cnt", {56'd0, dut.r_cnt}, 72'd256);
        term({64{1'b1}}, 1'b1);
        check_val("t3_ovf",     {71'd0, out_ovf}, 72'd1);
        check_val("t3_sum",     out_sum, exp_big);
        check_val("t3_cnt",     {56'd0, out_cnt}, 72'd257);
        check_val("t3_cnt_sat", {70'd0, out_cnt_s}, 72'd3);
        check_val("t3_ovf_s",   {71'd0, out_ovf_s}, 72'd1);
        step();

        // Counter saturation on the narrow instance; overflow flag restarts clear.
        for (int i = 0; i < 4; i++) begin
            term(64'd1, 1'b0);
        end
        term(64'd1, 1'b1);
        check_val("t6_sum",     out_sum, 72'd5);
        check_val("t6_cnt",     {56'd0, out_cnt}, 72'd5);
        check_val("t6_ovf",     {71'd0, out_ovf}, 72'd0);
        check_val("t6_sum_s",   out_sum_s, 72'd5);
        check_val("t6_cnt_s",   {70'd0, out_cnt_s}, 72'd3);
        check_val("t6_valid_s", {71'd0, out_valid_s}, 72'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
